spi_slave_frame: RTL and testbench
==================================

Name: spi_slave_frame

Overview:
- Parametrised SPI slave front end for the wrapper, sampled on the system clock (one MOSI bit per clk while SS_n is low).
- Deserialises command+data frames of DATA_W+2 bits and presents each completed frame to the RAM side.
- On read-data frames, serialises RAM response data onto MISO.
- Extends the current slave with configurable width, selectable MISO bit order, frame-abort detection and a response-wait timeout.

Parameters:
- DATA_W, 8, payload/address width; frame width is DATA_W+2 (2 command bits + payload).
- LSB_FIRST, 0, MISO response bit order: 0 = MSB first, 1 = LSB first. The MOSI frame is always MSB first.
- TX_WAIT_MAX, 16, max clk cycles to wait for tx_valid in a read-data response; 0 = wait forever.

Ports:
- clk  input  1  system/SPI sampling clock.
- rst  input  1  synchronous, active-high reset.
- SS_n  input  1  slave select, active low.
- MOSI  input  1  serial data in.
- tx_valid  input  1  tx_data valid (RAM read response).
- tx_data  input  DATA_W  read data to shift out.
- rx_data  output  DATA_W+2  completed frame {cmd[1:0], payload}.
- rx_valid  output  1  one-cycle pulse, rx_data valid.
- MISO  output  1  serial data out.
- frame_err  output  1  one-cycle pulse on abort or timeout.
- rd_pending  output  1  read address accepted, read data not yet returned.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (rst=1 at posedge): state IDLE; all outputs 0, including rx_data and rd_pending; internal counters cleared. Reset overrides everything, including mid-frame.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, RESP_WAIT, RESP_SHIFT, WAIT_END.
- IDLE: if SS_n=0, go to CHK_CMD.
- CHK_CMD, 1 cycle: sample MOSI as frame bit FRAME_W-1.
  - MOSI=0: go to WRITE.
  - MOSI=1 and rd_pending=0: go to READ_ADD.
  - MOSI=1 and rd_pending=1: go to READ_DATA.
- WRITE / READ_ADD / READ_DATA: sample one bit per cycle while SS_n=0, frame bits FRAME_W-2 down to 0.
  - After the last bit is sampled at cycle k, rx_data is updated and rx_valid=1 at cycle k+1 only.
  - Latency: rx_valid appears 11 cycles after the first SS_n-low cycle in IDLE (DATA_W=8).
- Frame-complete transitions:
  - From WRITE: go to WAIT_END.
  - From READ_ADD: set rd_pending=1, go to WAIT_END.
  - From READ_DATA: go to RESP_WAIT.
- RESP_WAIT:
  - When tx_valid=1 (cycle t): latch tx_data, go to RESP_SHIFT.
  - If TX_WAIT_MAX>0 and TX_WAIT_MAX cycles elapse without tx_valid: frame_err pulse, go to WAIT_END, rd_pending stays 1 so the master can retry.
  - tx_valid outside RESP_WAIT is ignored.
- RESP_SHIFT:
  - MISO drives the latched bits from cycle t+1 for DATA_W cycles: bit DATA_W-1 first if LSB_FIRST=0, bit 0 first if LSB_FIRST=1.
  - After the final bit: MISO=0, rd_pending cleared, go to WAIT_END.
- WAIT_END: extra MOSI bits are ignored; go to IDLE when SS_n=1.
- MISO is 0 in every state other than RESP_SHIFT.
- Abort: SS_n=1 sampled in CHK_CMD, WRITE, READ_ADD, READ_DATA, RESP_WAIT or RESP_SHIFT:
  - frame_err pulse next cycle, state IDLE, MISO=0.
  - No rx_valid; partial data discarded; rd_pending unchanged.
  - A bit on the same cycle SS_n rises is not sampled, so a frame missing only its last bit is an abort.
- Back-to-back frames: SS_n must return high (WAIT_END then IDLE) before the next frame starts. A continuously low SS_n never starts a new frame.
- rx_data holds its value until the next completed frame.

Test Plan:
- Write address: DATA_W=8, SS_n low, MOSI 00_1010_0101 -> rx_data=10'h0A5, rx_valid high exactly one cycle, 11 cycles after first SS_n-low cycle, MISO stays 0.
- Read sequence: frame 10_0011_0011 -> rx_data=10'h233, rd_pending=1. Then frame 11_0000_0000 with tx_valid and tx_data=8'hC1 -> MISO 1,1,0,0,0,0,0,1 over 8 cycles starting the cycle after tx_valid, then rd_pending=0.
- Bit order: same read sequence with LSB_FIRST=1 -> MISO 1,0,0,0,0,0,1,1.
- Abort: SS_n raised after 5 MOSI bits -> frame_err one cycle, no rx_valid, busy=0 next cycle, rx_data unchanged.
- Timeout: read-data frame completes, tx_valid held 0 for 16 cycles -> frame_err pulse, MISO=0, rd_pending=1. A retry read-data frame with tx_valid then succeeds.
- Reset mid-response: rst=1 during RESP_SHIFT bit 3 -> next cycle MISO=0, rd_pending=0, busy=0, rx_data=0, no frame_err.

Source files
------------

// File: rtl/spi_slave_frame.sv
// SPI slave frame engine: deserialises {cmd, payload} frames sampled on clk and
// serialises RAM read data onto MISO, with abort detection and response timeout.
module spi_slave_frame #(
  parameter int DATA_W      = 8,
  parameter bit LSB_FIRST   = 1'b0,
  parameter int TX_WAIT_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              MISO,
  output logic              frame_err,
  output logic              rd_pending,
  output logic              busy
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_MAX = (TX_WAIT_MAX > FRAME_W) ? TX_WAIT_MAX : FRAME_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(FRAME_W - 2);
  localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TX_WAIT_MAX > 0) ? TX_WAIT_MAX - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, RESP_WAIT, RESP_SHIFT, WAIT_END
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt;
  logic [FRAME_W-2:0]  rx_shift;
  logic [DATA_W-1:0]   tx_shift;
  logic                abort, rx_done, tx_load, tx_done, timeout;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    rx_done = 1'b0;
    tx_load = 1'b0;
    tx_done = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      IDLE:      if (!SS_n) state_d = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)            abort   = 1'b1;
        else if (!MOSI)      state_d = WRITE;
        else if (rd_pending) state_d = READ_DATA;
        else                 state_d = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) abort = 1'b1;
        else if (cnt == RX_LAST) begin
          rx_done = 1'b1;
          state_d = (state_q == READ_DATA) ? RESP_WAIT : WAIT_END;
        end
      end
      RESP_WAIT: begin
        if (SS_n) abort = 1'b1;
        else if (tx_valid) begin
          tx_load = 1'b1;
          state_d = RESP_SHIFT;
        end else if ((TX_WAIT_MAX > 0) && (cnt == WAIT_LAST)) begin
          timeout = 1'b1;
          state_d = WAIT_END;
        end
      end
      RESP_SHIFT: begin
        if (SS_n) abort = 1'b1;
        else if (cnt == TX_LAST) begin
          tx_done = 1'b1;
          state_d = WAIT_END;
        end
      end
      WAIT_END:  if (SS_n) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // cnt tracks cycles spent in the current state: bit index while shifting,
  // elapsed wait while in RESP_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      rd_pending <= 1'b0;
    end else begin
      cnt       <= (state_d == state_q) ? cnt + 1'b1 : '0;
      rx_valid  <= rx_done;
      frame_err <= abort | timeout;

      if (state_q == CHK_CMD)
        rx_shift <= {{(FRAME_W-2){1'b0}}, MOSI};
      else if (state_q inside {WRITE, READ_ADD, READ_DATA})
        rx_shift <= {rx_shift[FRAME_W-3:0], MOSI};

      if (rx_done) begin
        rx_data <= {rx_shift, MOSI};
        if (state_q == READ_ADD) rd_pending <= 1'b1;
      end

      if (tx_load)
        tx_shift <= tx_data;
      else if (state_q == RESP_SHIFT)
        tx_shift <= LSB_FIRST ? {1'b0, tx_shift[DATA_W-1:1]} : {tx_shift[DATA_W-2:0], 1'b0};

      if (tx_done) rd_pending <= 1'b0;
    end
  end

  assign MISO = (state_q == RESP_SHIFT) ? (LSB_FIRST ? tx_shift[0] : tx_shift[DATA_W-1]) : 1'b0;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_frame.sv
// Directed bench for spi_slave_frame: one MSB-first and one LSB-first instance
// share the same stimulus; expected values are hand-derived constants.
module tb_spi_slave_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic [9:0] rx_data, rx_data_l;
  logic       rx_valid, rx_valid_l, MISO, MISO_l;
  logic       frame_err, frame_err_l, rd_pending, rd_pending_l, busy, busy_l;

  int n_vec = 0;
  int n_err = 0;
  logic miso_seen;

  always #5 clk = ~clk;

  spi_slave_frame #(.DATA_W(8), .LSB_FIRST(1'b0), .TX_WAIT_MAX(16)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .tx_valid(tx_valid), .tx_data(tx_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .MISO(MISO), .frame_err(frame_err),
    .rd_pending(rd_pending), .busy(busy)
  );

  spi_slave_frame #(.DATA_W(8), .LSB_FIRST(1'b1), .TX_WAIT_MAX(16)) dut_lsb (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .tx_valid(tx_valid), .tx_data(tx_data),
    .rx_data(rx_data_l), .rx_valid(rx_valid_l), .MISO(MISO_l), .frame_err(frame_err_l),
    .rd_pending(rd_pending_l), .busy(busy_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle; outputs are sampled on the following negedge.
  task automatic drive(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd);
    SS_n     = ss;
    MOSI     = mosi;
    tx_valid = txv;
    tx_data  = txd;
    @(posedge clk);
    @(negedge clk);
    miso_seen = miso_seen | MISO | MISO_l;
  endtask

  // One IDLE cycle with SS_n low, then 10 frame bits MSB first. rv_cyc is the
  // cycle (relative to the IDLE cycle) in which rx_valid is first seen high.
  task automatic send_frame(input logic [9:0] f, output int rv_cnt, output int rv_cyc);
    rv_cnt = 0;
    rv_cyc = -1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 9; i >= 0; i--) begin
      drive(1'b0, f[i], 1'b0, 8'h00);
      if (rx_valid) begin
        rv_cnt++;
        if (rv_cyc < 0) rv_cyc = 11 - i;
      end
    end
  endtask

  task automatic get_resp(input logic [7:0] d, output logic [7:0] m, output logic [7:0] l);
    drive(1'b0, 1'b0, 1'b1, d);
    m[7] = MISO;
    l[7] = MISO_l;
    for (int j = 6; j >= 0; j--) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      m[j] = MISO;
      l[j] = MISO_l;
    end
  endtask

  initial begin
    int rvc, rvp, fe_cnt;
    logic [7:0] m, l;
    miso_seen = 1'b0;

    // Reset overrides SS_n low.
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    check("rst_rx_data", rx_data, 10'h000);
    check("rst_outputs", {rx_valid, MISO, frame_err, rd_pending, busy}, 5'b0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h00);

    // Write-address frame.
    miso_seen = 1'b0;
    send_frame(10'h0A5, rvc, rvp);
    check("wr_rx_data", rx_data, 10'h0A5);
    check("wr_rx_data_lsb", rx_data_l, 10'h0A5);
    check("wr_rv_latency", rvp, 11);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    if (rx_valid) rvc++;
    check("wr_rv_pulses", rvc, 1);
    check("wr_miso_quiet", miso_seen, 1'b0);
    check("wr_idle_busy", busy, 1'b0);
    check("wr_no_pending", rd_pending, 1'b0);

    // Read address then read data.
    send_frame(10'h233, rvc, rvp);
    check("rda_rx_data", rx_data, 10'h233);
    check("rda_pending", rd_pending, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    send_frame(10'h300, rvc, rvp);
    check("rdd_rx_data", rx_data, 10'h300);
    check("rdd_rv_pulses", rvc, 1);
    get_resp(8'hC1, m, l);
    check("rdd_miso_msb", m, 8'hC1);
    check("rdd_miso_lsb", l, 8'h83);
    check("rdd_pending_during", rd_pending, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("rdd_miso_after", {MISO, MISO_l}, 2'b00);
    check("rdd_pending_clr", {rd_pending, rd_pending_l}, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);

    // Abort after 5 MOSI bits.
    rvc = 0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, i[0], 1'b0, 8'h00);
      if (rx_valid) rvc++;
    end
    check("ab5_no_err_yet", frame_err, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    if (rx_valid) rvc++;
    check("ab5_frame_err", frame_err, 1'b1);
    check("ab5_busy", busy, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    if (rx_valid) rvc++;
    check("ab5_err_pulse", frame_err, 1'b0);
    check("ab5_no_rx_valid", rvc, 0);
    check("ab5_rx_data_held", rx_data, 10'h300);

    // Frame missing only its last bit is an abort.
    rvc = 0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 9; i >= 1; i--) begin
      drive(1'b0, i[0], 1'b0, 8'h00);
      if (rx_valid) rvc++;
    end
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    if (rx_valid) rvc++;
    check("ab9_frame_err", frame_err, 1'b1);
    check("ab9_no_rx_valid", rvc, 0);
    check("ab9_rx_data_held", rx_data, 10'h300);
    drive(1'b1, 1'b0, 1'b0, 8'h00);

    // Response timeout, then retry.
    send_frame(10'h25A, rvc, rvp);
    check("to_rda_rx_data", rx_data, 10'h25A);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    send_frame(10'h3FF, rvc, rvp);
    fe_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'hAA);
      if (frame_err) fe_cnt++;
    end
    check("to_no_early_err", fe_cnt, 0);
    drive(1'b0, 1'b1, 1'b0, 8'hAA);
    check("to_frame_err", {frame_err, frame_err_l}, 2'b11);
    check("to_miso", MISO, 1'b0);
    check("to_pending", rd_pending, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 8'hAA);
    check("to_err_pulse", frame_err, 1'b0);
    check("to_wait_end_busy", busy, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    send_frame(10'h300, rvc, rvp);
    get_resp(8'h96, m, l);
    check("retry_miso_msb", m, 8'h96);
    check("retry_miso_lsb", l, 8'h69);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("retry_pending_clr", rd_pending, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h00);

    // Reset in the middle of the MISO response.
    send_frame(10'h2AA, rvc, rvp);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    send_frame(10'h300, rvc, rvp);
    drive(1'b0, 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("mid_pre_miso", MISO, 1'b1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    check("mid_rst_miso", {MISO, MISO_l}, 2'b00);
    check("mid_rst_pending", rd_pending, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rx_data", rx_data, 10'h000);
    check("mid_rst_frame_err", frame_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
